kalman_adc_frontend: RTL and testbench

Conditions raw ADC channel-A samples into the signed 16-bit measurement stream consumed by the Kalman filter core. The block sits directly upstream of the filter in the `adc_clk` domain. It performs four steps:
- converts the ADC's inverted-offset format to two's complement;
- subtracts a programmable DC offset;
- boxcar-averages and decimates by 2^DEC_LOG2;
- saturates the result to 16 bits.

Results are delivered over a valid/ready handshake, with sticky overflow and saturation flags.

---
 rtl/kalman_adc_frontend.sv | 120 ++++++++++++
 tb/tb_kalman_adc_frontend.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/kalman_adc_frontend.sv
// kalman_adc_frontend: converts raw ADC channel-A words to signed 16-bit
// measurements for the Kalman core. The steps are format conversion, DC
// offset removal, a 2^DEC_LOG2 boxcar average with decimation, and 16-bit
// saturation. Results leave through a valid/ready output register with
// sticky overflow and saturation flags.
module kalman_adc_frontend #(
  parameter int unsigned DEC_LOG2 = 3
) (
  input  logic        adc_clk,
  input  logic        adc_rstn,
  input  logic [13:0] adc_dat_i,
  input  logic        adc_en_i,
  input  logic [15:0] offset_i,
  output logic [15:0] z_dat_o,
  output logic        z_valid_o,
  input  logic        z_ready_i,
  output logic        ovf_o,
  output logic        sat_o,
  input  logic        clr_i
);

  // Accumulator must hold 2^DEC_LOG2 worst-case 17-bit differences.
  localparam int unsigned AW = 17 + DEC_LOG2;
  // Counter keeps at least one bit; with DEC_LOG2=0 it stays at 0, so every
  // sample is the last one.
  localparam int unsigned CW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'((1 << DEC_LOG2) - 1);
  localparam logic signed [AW-1:0] ZMAX     = AW'(32767);
  localparam logic signed [AW-1:0] ZMIN     = AW'(-32768);

  // vld_pipe_q[0]: conv_q is valid; vld_pipe_q[1]: d_q is valid
  logic [1:0]              vld_pipe_q;
  logic signed [13:0]      conv_q;
  logic signed [16:0]      d_q, d_d;
  logic signed [AW-1:0]    acc_q, acc_d, d_ext, sum, sh;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [15:0]             z_q, z_d, res;
  logic                    zv_q, zv_d, ovf_q, ovf_d, sat_q, sat_d;
  logic                    last, done, clipped, load, drop;

  // Offset stage: widen both operands to 17 bits so the difference never wraps
  assign d_d = 17'({{3{conv_q[13]}}, conv_q}) - 17'({offset_i[15], offset_i});

  // Accumulate and finish: sum, arithmetic shift (floor), clip
  always_comb begin
    d_ext   = AW'(d_q);
    sum     = acc_q + d_ext;
    sh      = sum >>> DEC_LOG2;
    last    = (cnt_q == CNT_LAST);
    done    = vld_pipe_q[1] && last;
    clipped = (sh > ZMAX) || (sh < ZMIN);
    res     = (sh > ZMAX) ? 16'h7FFF : (sh < ZMIN) ? 16'h8000 : 16'(sh);
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (vld_pipe_q[1]) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Output register and sticky flags; a set event beats a clear
  always_comb begin
    load  = done && (!zv_q || z_ready_i);
    drop  = done && zv_q && !z_ready_i;
    z_d   = z_q;
    zv_d  = zv_q;
    ovf_d = clr_i ? 1'b0 : ovf_q;
    sat_d = clr_i ? 1'b0 : sat_q;
    if (zv_q && z_ready_i) zv_d = 1'b0;
    if (load) begin
      z_d  = res;
      zv_d = 1'b1;
    end
    if (drop)            ovf_d = 1'b1;
    if (done && clipped) sat_d = 1'b1;
  end

  // Capture and offset pipeline; stages advance only on their own valid bit
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      vld_pipe_q <= '0;
      conv_q     <= '0;
      d_q        <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], adc_en_i};
      if (adc_en_i)      conv_q <= {adc_dat_i[13], ~adc_dat_i[12:0]};
      if (vld_pipe_q[0]) d_q    <= d_d;
    end
  end

  // Accumulator, sample counter, output register and flags
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      acc_q <= '0;
      cnt_q <= '0;
      z_q   <= '0;
      zv_q  <= 1'b0;
      ovf_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      z_q   <= z_d;
      zv_q  <= zv_d;
      ovf_q <= ovf_d;
      sat_q <= sat_d;
    end
  end

  assign z_dat_o   = z_q;
  assign z_valid_o = zv_q;
  assign ovf_o     = ovf_q;
  assign sat_o     = sat_q;

endmodule

// File: tb/tb_kalman_adc_frontend.sv
// Directed bench for kalman_adc_frontend: a DEC_LOG2=0 instance and a
// DEC_LOG2=3 instance driven from hand-computed vectors.
module tb_kalman_adc_frontend;

  logic        adc_clk = 1'b0;
  logic        adc_rstn;
  logic [13:0] a0_dat, a3_dat;
  logic        a0_en, a3_en;
  logic [15:0] off0, off3;
  logic [15:0] z0, z3;
  logic        zv0, zv3, rdy0, rdy3, ovf0, ovf3, sat0, sat3, clr0, clr3;

  int n_tot = 0;
  int n_bad = 0;

  always #5 adc_clk = ~adc_clk;

  kalman_adc_frontend #(.DEC_LOG2(0)) u_dut0 (
    .adc_clk(adc_clk), .adc_rstn(adc_rstn), .adc_dat_i(a0_dat), .adc_en_i(a0_en),
    .offset_i(off0), .z_dat_o(z0), .z_valid_o(zv0), .z_ready_i(rdy0),
    .ovf_o(ovf0), .sat_o(sat0), .clr_i(clr0)
  );

  kalman_adc_frontend #(.DEC_LOG2(3)) u_dut3 (
    .adc_clk(adc_clk), .adc_rstn(adc_rstn), .adc_dat_i(a3_dat), .adc_en_i(a3_en),
    .offset_i(off3), .z_dat_o(z3), .z_valid_o(zv3), .z_ready_i(rdy3),
    .ovf_o(ovf3), .sat_o(sat3), .clr_i(clr3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // step past the next rising edge; checks and drives happen 1 time unit later
  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic zeros(input string tag);
    chk({tag, "_z0"},  32'(z0),   32'h0);
    chk({tag, "_v0"},  32'(zv0),  32'h0);
    chk({tag, "_o0"},  32'(ovf0), 32'h0);
    chk({tag, "_s0"},  32'(sat0), 32'h0);
    chk({tag, "_z3"},  32'(z3),   32'h0);
    chk({tag, "_v3"},  32'(zv3),  32'h0);
    chk({tag, "_o3"},  32'(ovf3), 32'h0);
    chk({tag, "_s3"},  32'(sat3), 32'h0);
  endtask

  initial begin
    adc_rstn = 1'b0;
    a0_dat = '0; a3_dat = '0; a0_en = 0; a3_en = 0;
    off0 = '0; off3 = '0; rdy0 = 0; rdy3 = 0; clr0 = 0; clr3 = 0;
    tick(); tick();
    zeros("rst");
    adc_rstn = 1'b1;
    tick();
    zeros("post_rst");

    // pass-through: 0x0000 -> 8191, 0x3FFF -> -8192
    rdy0 = 1;
    a0_dat = 14'h0000; a0_en = 1; tick();
    a0_dat = 14'h3FFF; tick();
    a0_en = 0;
    chk("pt_early_v", 32'(zv0), 32'h0);
    tick();
    chk("pt1_z", 32'(z0), 32'h1FFF);
    chk("pt1_v", 32'(zv0), 32'h1);
    tick();
    chk("pt2_z", 32'(z0), 32'hE000);
    chk("pt2_v", 32'(zv0), 32'h1);
    tick();
    chk("pt_drain_v", 32'(zv0), 32'h0);

    // back-pressure: conv 5 then 7 with ready low; 7 is dropped
    rdy0 = 0;
    a0_dat = 14'h1FFA; a0_en = 1; tick();
    a0_dat = 14'h1FF8; tick();
    a0_en = 0; tick();
    chk("bp1_z", 32'(z0), 32'd5);
    chk("bp1_o", 32'(ovf0), 32'h0);
    tick();
    chk("bp2_z", 32'(z0), 32'd5);
    chk("bp2_v", 32'(zv0), 32'h1);
    chk("bp2_o", 32'(ovf0), 32'h1);
    rdy0 = 1; tick();
    chk("bp_acc_v", 32'(zv0), 32'h0);
    chk("bp_o_hold", 32'(ovf0), 32'h1);
    rdy0 = 0; clr0 = 1; tick();
    clr0 = 0;
    chk("bp_clr_o", 32'(ovf0), 32'h0);

    // simultaneous accept and load
    a0_dat = 14'h1FFA; a0_en = 1; tick();
    a0_en = 0; tick(); tick();
    chk("sim_hold_z", 32'(z0), 32'd5);
    a0_dat = 14'h1FF8; a0_en = 1; tick();
    a0_en = 0; tick();
    rdy0 = 1; tick();
    chk("sim_z", 32'(z0), 32'd7);
    chk("sim_v", 32'(zv0), 32'h1);
    chk("sim_o", 32'(ovf0), 32'h0);
    tick();
    chk("sim_drain_v", 32'(zv0), 32'h0);

    // saturation high, then low with clr in the same cycle
    chk("sat_pre", 32'(sat0), 32'h0);
    off0 = 16'h8000; a0_dat = 14'h0000; a0_en = 1; tick();
    a0_en = 0; tick(); tick();
    chk("sath_z", 32'(z0), 32'h7FFF);
    chk("sath_s", 32'(sat0), 32'h1);
    off0 = 16'h7FFF; a0_dat = 14'h3FFF; a0_en = 1; tick();
    a0_en = 0; tick();
    clr0 = 1; tick();
    chk("satl_z", 32'(z0), 32'h8000);
    chk("satl_s", 32'(sat0), 32'h1);
    tick();
    clr0 = 0;
    chk("sat_clr", 32'(sat0), 32'h0);

    // averaging: 8 x conv 1000, offset 100, 3-cycle gap -> 900
    off3 = 16'd100;
    for (int i = 0; i < 8; i++) begin
      a3_dat = 14'h1C17; a3_en = 1; tick();
      if (i == 3) begin
        a3_en = 0; tick(); tick(); tick();
      end
      if (i == 6) chk("avg_pre_v", 32'(zv3), 32'h0);
    end
    a3_en = 0;
    tick();
    chk("avg_t1_v", 32'(zv3), 32'h0);
    tick();
    chk("avg_z", 32'(z3), 32'd900);
    chk("avg_v", 32'(zv3), 32'h1);
    tick();
    chk("avg_hold_z", 32'(z3), 32'd900);

    // reset mid-block: 5 samples of 1000 are discarded
    off3 = 16'd0;
    for (int i = 0; i < 5; i++) begin
      a3_dat = 14'h1C17; a3_en = 1; tick();
    end
    a3_en = 0; tick(); tick();
    #2 adc_rstn = 1'b0;
    #1 zeros("mid_rst");
    tick();
    zeros("mid_rst_edge");
    adc_rstn = 1'b1;
    rdy3 = 1;
    for (int i = 0; i < 8; i++) begin
      a3_dat = 14'h2007; a3_en = 1; tick();
    end
    a3_en = 0; tick(); tick();
    chk("rst_blk_z", 32'(z3), 32'h0000FFF8);
    chk("rst_blk_v", 32'(zv3), 32'h1);
    chk("rst_blk_o", 32'(ovf3), 32'h0);

    // floor rounding: 7 x -8 plus one -7 -> -63 >>> 3 = -8
    for (int i = 0; i < 8; i++) begin
      a3_dat = (i == 7) ? 14'h2006 : 14'h2007; a3_en = 1; tick();
    end
    a3_en = 0;
    chk("floor_pre_v", 32'(zv3), 32'h0);
    tick(); tick();
    chk("floor_z", 32'(z3), 32'h0000FFF8);
    chk("floor_v", 32'(zv3), 32'h1);
    chk("floor_s", 32'(sat3), 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
